// File: rtl/qq_cmd_frontend.sv
// qq_cmd_frontend: command FIFO, one-at-a-time issue FSM and in-order response collector for the QuickQueue.
module qq_cmd_frontend #(
  parameter int W      = 32,
  parameter int D      = 4,
  parameter int FD     = 4,
  parameter int OP_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [W-1:0]             cmd_data,
  output logic                     enq,
  output logic                     deq,
  output logic [W-1:0]             data_lt_i,
  output logic [31:0]              array_size,
  input  logic [W-1:0]             q_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_data,
  output logic                     rsp_err,
  output logic [$clog2(D+1)-1:0]   count
);
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(D+1);
  localparam int LW = $clog2(OP_LAT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t         state_q, state_d;
  logic [W:0]     mem_q [FD];
  logic [W:0]     mem_d [FD];
  logic [PW:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic           op_q, op_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           push, pop, empty, can_enq, can_deq, head_op;
  logic [W-1:0]   head_data;
  assign empty            = wr_q == rd_q;
  assign cmd_ready        = (wr_q - rd_q) != (PW+1)'(FD);
  assign push             = cmd_valid && cmd_ready;
  assign pop              = state_q == ISSUE;
  assign {head_op, head_data} = mem_q[rd_q[PW-1:0]];
  assign can_enq          = !head_op && count_q != CW'(D);
  assign can_deq          = head_op && count_q != '0;
  // Pulses are masked during reset so a stale ISSUE state cannot reach the queue.
  assign enq              = !rst && pop && can_enq;
  assign deq              = !rst && pop && can_deq;
  assign data_lt_i        = enq ? head_data : '0;
  assign array_size       = 32'(D);
  assign rsp_valid        = state_q == RESP;
  assign rsp_data         = rsp_data_q;
  assign rsp_err          = rsp_err_q;
  assign count            = count_q;
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_d       = wr_q + (PW+1)'(push);
    rd_d       = rd_q + (PW+1)'(pop);
    count_d    = count_q;
    lat_d      = lat_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (push) mem_d[wr_q[PW-1:0]] = {cmd_op, cmd_data};
    case (state_q)
      IDLE:  state_d = empty ? IDLE : ISSUE;
      ISSUE: begin
        op_d  = head_op;
        lat_d = LW'(OP_LAT - 1);
        if (can_enq || can_deq) begin
          count_d = can_enq ? count_q + CW'(1) : count_q - CW'(1);
          state_d = WAIT;
        end else begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          rsp_data_d = op_q ? q_data : '0;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      lat_q      <= '0;
      op_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      lat_q      <= lat_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_qq_cmd_frontend.sv
// tb_qq_cmd_frontend: directed bench with a min-first queue model whose output settles exactly OP_LAT cycles after deq.
module tb_qq_cmd_frontend;
  localparam int W = 32, D = 4, FD = 4, OP_LAT = 3;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_op = 0, rsp_ready = 0;
  logic [W-1:0] cmd_data = '0;
  logic cmd_ready, enq, deq, rsp_valid, rsp_err;
  logic [W-1:0] data_lt_i, q_data, rsp_data;
  logic [31:0] array_size;
  logic [2:0] count;
  int tests = 0, fails = 0;
  int enq_cnt = 0, deq_cnt = 0, both = 0, cyc = 0, last_deq = -100, min_gap = 1000, rsp_cyc = 0, st = 0, snap = 0;
  logic [W-1:0] last_enq_data = '0, pend = '0;
  logic [W-1:0] mq[$];

  qq_cmd_frontend #(.W(W), .D(D), .FD(FD), .OP_LAT(OP_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .enq(enq), .deq(deq), .data_lt_i(data_lt_i), .array_size(array_size),
    .q_data(q_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .count(count));

  always #5 clk = ~clk;

  // Dequeued value is visible only in the single cycle the front-end should sample it.
  assign q_data = (st == 1) ? pend : 32'hDEADBEEF;

  always @(negedge clk) begin
    cyc++;
    if (rsp_valid) rsp_cyc++;
    if (st > 0) st--;
    if (rst) begin
      mq.delete();
      st = 0;
    end
    if (enq && deq) both++;
    if (enq) begin
      enq_cnt++;
      last_enq_data = data_lt_i;
      mq.push_back(data_lt_i);
    end
    if (deq) begin
      int mi;
      deq_cnt++;
      if (cyc - last_deq < min_gap) min_gap = cyc - last_deq;
      last_deq = cyc;
      pend = 32'hBAD0BAD0;
      if (mq.size() > 0) begin
        mi = 0;
        for (int i = 1; i < mq.size(); i++) if (mq[i] < mq[mi]) mi = i;
        pend = mq[mi];
        mq.delete(mi);
      end
      st = OP_LAT + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic op, input logic [W-1:0] d);
    int n = 0;
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("send_ready_timeout", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic get_rsp(input string tag, input logic [W-1:0] ed, input logic ee, input int elat);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 1);
    if (elat >= 0) check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_data"}, rsp_data, ed);
    check({tag, "_err"}, 32'(rsp_err), 32'(ee));
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_count", 32'(count), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_data_lt_i", data_lt_i, 0);
    check("array_size", array_size, 4);
    repeat (10) tick();
    check("idle_enq_pulses", 32'(enq_cnt), 0);
    check("idle_deq_pulses", 32'(deq_cnt), 0);

    send(0, 5);
    get_rsp("enq5", 0, 0, OP_LAT + 2);
    check("enq5_lt_data", last_enq_data, 5);
    check("cnt1", 32'(count), 1);
    send(0, 9);
    get_rsp("enq9", 0, 0, OP_LAT + 2);
    check("cnt2", 32'(count), 2);
    send(0, 2);
    get_rsp("enq2", 0, 0, OP_LAT + 2);
    check("cnt3", 32'(count), 3);
    send(1, 0);
    get_rsp("deq_a", 2, 0, OP_LAT + 2);
    check("cnt2b", 32'(count), 2);
    send(1, 0);
    get_rsp("deq_b", 5, 0, OP_LAT + 2);
    check("cnt1b", 32'(count), 1);
    send(1, 0);
    get_rsp("deq_c", 9, 0, OP_LAT + 2);
    check("cnt0", 32'(count), 0);
    check("enq_pulses_3", 32'(enq_cnt), 3);
    check("deq_pulses_3", 32'(deq_cnt), 3);

    send(1, 0);
    get_rsp("deq_empty", 0, 1, 2);
    check("deq_empty_pulses", 32'(deq_cnt), 3);
    check("deq_empty_cnt", 32'(count), 0);

    for (int i = 1; i <= 5; i++) begin
      send(0, 32'(10 * i));
      get_rsp($sformatf("fill%0d", i), 0, (i == 5), (i == 5) ? 2 : OP_LAT + 2);
    end
    check("full_cnt", 32'(count), 4);
    check("full_enq_pulses", 32'(enq_cnt), 7);
    check("full_last_enq", last_enq_data, 40);
    for (int i = 1; i <= 4; i++) begin
      send(1, 0);
      get_rsp($sformatf("drain%0d", i), 32'(10 * i), 0, OP_LAT + 2);
    end
    check("drain_cnt", 32'(count), 0);

    send(0, 42);
    get_rsp("pre42", 0, 0, OP_LAT + 2);
    send(1, 0);
    send(0, 7);
    send(0, 3);
    send(1, 0);
    send(1, 0);
    check("bp_full_ready", 32'(cmd_ready), 0);
    cmd_valid = 1;
    cmd_op = 0;
    cmd_data = 8;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp_hold_ready%0d", i), 32'(cmd_ready), 0);
      check($sformatf("bp_hold_data%0d", i), rsp_data, 42);
    end
    get_rsp("bp0", 42, 0, 0);
    send(0, 8);
    get_rsp("bp1", 0, 0, -1);
    get_rsp("bp2", 0, 0, -1);
    get_rsp("bp3", 3, 0, -1);
    get_rsp("bp4", 7, 0, -1);
    get_rsp("bp5", 0, 0, -1);
    check("bp_cnt", 32'(count), 1);
    check("bp_enq_pulses", 32'(enq_cnt), 11);

    send(1, 0);
    tick();
    check("rw_deq_issue", 32'(deq), 1);
    tick();
    rst = 1;
    #1;
    check("rw_rst_deq", 32'(deq), 0);
    tick();
    rst = 0;
    check("rw_after_deq", 32'(deq), 0);
    check("rw_after_enq", 32'(enq), 0);
    check("rw_cnt", 32'(count), 0);
    check("rw_ready", 32'(cmd_ready), 1);
    snap = rsp_cyc;
    repeat (10) tick();
    check("rw_no_rsp", 32'(rsp_cyc), 32'(snap));
    check("rw_deq_pulses", 32'(deq_cnt), 11);
    send(1, 0);
    get_rsp("rw_deq_empty", 0, 1, 2);
    check("never_both", 32'(both), 0);
    check("deq_gap_ok", 32'(min_gap >= 6), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
